// File: rtl/data_mem_be.sv
// -----------------------------------------------------------------------------
// data_mem_be
//
// Single-port data memory for the load/store stage of the datapath.
// It supports byte-enable writes and a registered read path with a latency of
// 1 or 2 cycles, marked by a one-cycle valid strobe. It flags misaligned and
// out-of-range addresses. A sequential clear engine zeroes one word per cycle
// and holds mem_busy high while it runs.
//
// Parameters
//   DATA_W    word width in bits (multiple of 8)
//   DEPTH     number of words (power of two, >= 4)
//   ADDR_W    byte-address width
//   READ_LAT  read latency in cycles (1 or 2)
//
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   synchronous active-low reset
//   mem_access_addr  in   byte address of the request
//   mem_write_data   in   write data
//   mem_byte_en      in   per-byte write enable, bit k -> bits [8k+7:8k]
//   mem_write_en     in   write request
//   mem_read         in   read request
//   mem_clear        in   one-cycle pulse that starts the clear engine
//   mem_read_data    out  registered read data; holds its value between reads
//   mem_read_valid   out  one-cycle strobe that marks mem_read_data as fresh
//   mem_addr_err     out  error flag for the request accepted one edge earlier
//   mem_busy         out  high while the clear engine runs
// -----------------------------------------------------------------------------
module data_mem_be #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     mem_access_addr,
    input  logic [DATA_W-1:0]     mem_write_data,
    input  logic [DATA_W/8-1:0]   mem_byte_en,
    input  logic                  mem_write_en,
    input  logic                  mem_read,
    input  logic                  mem_clear,
    output logic [DATA_W-1:0]     mem_read_data,
    output logic                  mem_read_valid,
    output logic                  mem_addr_err,
    output logic                  mem_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BE_W);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] w_word_idx;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_err;

    assign w_word_idx = mem_access_addr[OFF_W+IDX_W-1 : OFF_W];

    // Byte-wide words have no offset bits and so can never be misaligned.
    generate
        if (OFF_W > 0) begin : g_offset
            assign w_misaligned = |mem_access_addr[(OFF_W > 0 ? OFF_W-1 : 0) : 0];
        end else begin : g_no_offset
            assign w_misaligned = 1'b0;
        end

        // Address bits above the word index must be zero. If the index
        // already uses every address bit, the address is always in range.
        if (OFF_W + IDX_W < ADDR_W) begin : g_high_bits
            assign w_out_of_range = |mem_access_addr[ADDR_W-1 : OFF_W+IDX_W];
        end else begin : g_no_high_bits
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_err = w_misaligned | w_out_of_range;

    // -------------------------------------------------------------------------
    // Clear FSM
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [IDX_W-1:0] r_clr_cnt;
    logic             r_busy;

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments. Every
        // register then samples its pre-edge value, whatever order the
        // statements appear in.
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_clear) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // The word at r_clr_cnt is zeroed at this edge.
                    r_clr_cnt <= r_clr_cnt + IDX_W'(1);
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_busy = r_busy;

    // -------------------------------------------------------------------------
    // Request acceptance
    // -------------------------------------------------------------------------
    // A request is taken only in IDLE, outside reset, and only when the same
    // cycle is not also launching a clear. A clear pulse wins over a request.
    logic w_req_ok;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_clr_we;

    assign w_req_ok = rst_n && (r_state == S_IDLE) && !mem_clear;
    assign w_rd_acc = w_req_ok && mem_read;
    assign w_wr_acc = w_req_ok && mem_write_en;
    // Gating with rst_n lets a reset that lands during a clear stop the
    // engine before it zeroes the word it was about to write.
    assign w_clr_we = rst_n && (r_state == S_CLEAR);

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch. Reset must leave the contents
    // intact, and a reset port would stop the array from mapping onto RAM.
    // The declaration initialiser sets the power-up value only.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc && !w_err) begin
            for (int k = 0; k < BE_W; k++) begin
                if (mem_byte_en[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= mem_write_data[8*k +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read stage 1 and error flag
    // -------------------------------------------------------------------------
    // Reading r_mem at the acceptance edge returns the pre-write contents.
    // This gives read-first behaviour when a read and a write hit the same word.
    logic [DATA_W-1:0] r_rd_data1;
    logic              r_rd_valid1;
    logic              r_addr_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data1  <= '0;
            r_rd_valid1 <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_rd_valid1 <= w_rd_acc;
            r_addr_err  <= (w_rd_acc || w_wr_acc) && w_err;
            if (w_rd_acc) begin
                r_rd_data1 <= w_err ? '0 : r_mem[w_word_idx];
            end
        end
    end

    assign mem_addr_err = r_addr_err;

    // -------------------------------------------------------------------------
    // Optional second output stage
    // -------------------------------------------------------------------------
    // This stage is not gated by the clear engine. A read already in flight
    // when a clear starts still delivers its result.
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rd_data2;
            logic              r_rd_valid2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rd_data2  <= '0;
                    r_rd_valid2 <= 1'b0;
                end else begin
                    r_rd_valid2 <= r_rd_valid1;
                    if (r_rd_valid1) begin
                        r_rd_data2 <= r_rd_data1;
                    end
                end
            end

            assign mem_read_data  = r_rd_data2;
            assign mem_read_valid = r_rd_valid2;
        end else begin : g_lat1
            assign mem_read_data  = r_rd_data1;
            assign mem_read_valid = r_rd_valid1;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_be.sv
// -----------------------------------------------------------------------------
// tb_data_mem_be
//
// Two instances of data_mem_be (READ_LAT=1 and READ_LAT=2) are driven with the
// same stimulus. After every clock edge, both instances are compared with a
// behavioural model: an array of words plus the expected output values. The
// directed steps cover the byte-lane, read-first, error, pipeline, clear and
// reset-during-clear scenarios, and a randomized phase sits between them.
// -----------------------------------------------------------------------------
module tb_data_mem_be;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        rd;
    logic        clr;

    logic [31:0] rdata1, rdata2;
    logic        valid1, valid2;
    logic        err1, err2;
    logic        busy1, busy2;

    data_mem_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(1)) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_access_addr (addr),
        .mem_write_data  (wdata),
        .mem_byte_en     (be),
        .mem_write_en    (we),
        .mem_read        (rd),
        .mem_clear       (clr),
        .mem_read_data   (rdata1),
        .mem_read_valid  (valid1),
        .mem_addr_err    (err1),
        .mem_busy        (busy1)
    );

    data_mem_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(2)) u_dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_access_addr (addr),
        .mem_write_data  (wdata),
        .mem_byte_en     (be),
        .mem_write_en    (we),
        .mem_read        (rd),
        .mem_clear       (clr),
        .mem_read_data   (rdata2),
        .mem_read_valid  (valid2),
        .mem_addr_err    (err2),
        .mem_busy        (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    bit          m_busy;
    int          m_clr_pos;
    bit          e1_v, e2_v, e_err;
    logic [31:0] e1_d, e2_d;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Applies the driven inputs to the model as one clock edge.
    task automatic model_edge();
        bit          rd_ok, wr_ok, bad;
        logic [31:0] old;
        logic [31:0] mask;
        int          w;
        if (!rst_n) begin
            m_busy    = 0;
            m_clr_pos = 0;
            e1_v = 0; e1_d = '0;
            e2_v = 0; e2_d = '0;
            e_err = 0;
            return;
        end
        // The 2-cycle instance shows the result the 1-cycle instance showed
        // one edge earlier.
        e2_v = e1_v;
        if (e1_v) e2_d = e1_d;

        rd_ok = !m_busy && !clr && rd;
        wr_ok = !m_busy && !clr && we;
        bad   = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        w     = int'((addr / 4) % DEPTH);
        old   = bad ? 32'h0 : m_mem[w];

        if (m_busy) begin
            m_mem[m_clr_pos] = '0;
            m_clr_pos++;
            if (m_clr_pos == DEPTH) m_busy = 0;
        end else if (clr) begin
            m_busy    = 1;
            m_clr_pos = 0;
        end

        if (wr_ok && !bad) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mask     = 32'hFF << (8 * k);
                    m_mem[w] = (m_mem[w] & ~mask) | (wdata & mask);
                end
            end
        end

        e1_v = rd_ok;
        if (rd_ok) e1_d = old;
        e_err = (rd_ok || wr_ok) && bad;
    endtask

    // Runs one clock edge, then compares every output of both instances.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("busy_l1",  {31'b0, busy1},  {31'b0, m_busy});
        check("err_l1",   {31'b0, err1},   {31'b0, e_err});
        check("valid_l1", {31'b0, valid1}, {31'b0, e1_v});
        check("data_l1",  rdata1, e1_d);
        check("busy_l2",  {31'b0, busy2},  {31'b0, m_busy});
        check("err_l2",   {31'b0, err2},   {31'b0, e_err});
        check("valid_l2", {31'b0, valid2}, {31'b0, e2_v});
        check("data_l2",  rdata2, e2_d);
    endtask

    task automatic idle_inputs();
        addr = '0; wdata = '0; be = '0; we = 0; rd = 0; clr = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1; rd = 0; clr = 0;
        tick();
        idle_inputs();
    endtask

    task automatic do_read(input logic [31:0] a);
        addr = a; rd = 1; we = 0; clr = 0;
        tick();
        idle_inputs();
    endtask

    int busy_cnt;
    int sel;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = 0; m_clr_pos = 0;
        e1_v = 0; e2_v = 0; e_err = 0; e1_d = '0; e2_d = '0;
        rst_n = 0;
        idle_inputs();

        // Reset: every output returns to zero.
        tick();
        tick();
        check("reset_busy",  {31'b0, busy1},  32'd0);
        check("reset_valid", {31'b0, valid2}, 32'd0);
        rst_n = 1;
        tick();

        // Byte-lane merge.
        do_write(32'h10, 32'hAABBCCDD, 4'b1111);
        do_write(32'h10, 32'h11223344, 4'b0101);
        do_read(32'h10);
        check("be_merge_data",  rdata1, 32'hAA22CC44);
        check("be_merge_valid", {31'b0, valid1}, 32'd1);
        tick();
        check("be_valid_single", {31'b0, valid1}, 32'd0);
        check("be_merge_l2",     rdata2, 32'hAA22CC44);

        // Read-first on a same-word collision.
        addr = 32'h20; wdata = 32'h12345678; be = 4'hF; we = 1; rd = 1;
        tick();
        idle_inputs();
        check("rf_old", rdata1, 32'h0);
        do_read(32'h20);
        check("rf_new", rdata1, 32'h12345678);

        // Misaligned read and out-of-range write.
        do_read(32'h22);
        check("misalign_valid", {31'b0, valid1}, 32'd1);
        check("misalign_data",  rdata1, 32'h0);
        check("misalign_err",   {31'b0, err1}, 32'd1);
        do_write(32'h400, 32'hDEADBEEF, 4'hF);
        check("range_err", {31'b0, err1}, 32'd1);
        do_read(32'h0);
        check("range_word0", rdata1, 32'h0);
        check("range_err_clr", {31'b0, err1}, 32'd0);

        // Back-to-back reads with latency 2.
        do_write(32'h0, 32'h0A0A0A0A, 4'hF);
        do_write(32'h4, 32'h0B0B0B0B, 4'hF);
        do_write(32'h8, 32'h0C0C0C0C, 4'hF);
        rd = 1; addr = 32'h0;
        tick();
        check("l2_first_none", {31'b0, valid2}, 32'd0);
        addr = 32'h4;
        tick();
        check("l2_v0", {31'b0, valid2}, 32'd1);
        check("l2_d0", rdata2, 32'h0A0A0A0A);
        addr = 32'h8;
        tick();
        check("l2_v1", {31'b0, valid2}, 32'd1);
        check("l2_d1", rdata2, 32'h0B0B0B0B);
        idle_inputs();
        tick();
        check("l2_v2", {31'b0, valid2}, 32'd1);
        check("l2_d2", rdata2, 32'h0C0C0C0C);
        tick();
        check("l2_done", {31'b0, valid2}, 32'd0);

        // Randomized traffic, concentrated on a few words so that reads hit
        // words that were written.
        for (int n = 0; n < 300; n++) begin
            sel   = int'($urandom_range(0, 7));
            rd    = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            be    = 4'($urandom);
            wdata = $urandom;
            if (sel == 0)      addr = $urandom;
            else if (sel == 1) addr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else               addr = 32'($urandom_range(0, 15) * 4);
            tick();
        end
        idle_inputs();
        tick();

        // Full clear; a write issued during the clear must be ignored.
        for (int i = 0; i < DEPTH; i++) do_write(32'(i * 4), 32'hFFFFFFFF, 4'hF);
        clr = 1; rd = 1; addr = 32'h40;    // the clear wins; the read is dropped
        tick();
        idle_inputs();
        check("clr_drop_read", {31'b0, valid1}, 32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 400 && busy1; c++) begin
            busy_cnt++;
            if (busy_cnt == 50) begin
                addr = 32'h40; wdata = 32'h5A5A5A5A; be = 4'hF; we = 1; clr = 1;
            end
            tick();
            idle_inputs();
        end
        check("clr_busy_len", 32'(busy_cnt), 32'd256);
        for (int i = 0; i < DEPTH; i++) begin
            do_read(32'(i * 4));
            check("clr_word_zero", rdata1, 32'h0);
        end

        // Reset during a clear.
        for (int i = 0; i < DEPTH; i++) do_write(32'(i * 4), 32'hFFFFFFFF, 4'hF);
        clr = 1;
        tick();
        idle_inputs();
        repeat (100) tick();
        rst_n = 0; we = 1; rd = 1; addr = 32'h200; wdata = 32'h0; be = 4'hF;
        tick();
        check("rst_busy",  {31'b0, busy1},  32'd0);
        check("rst_valid", {31'b0, valid1}, 32'd0);
        check("rst_err",   {31'b0, err1},   32'd0);
        rst_n = 1;
        idle_inputs();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            do_read(32'(i * 4));
            check("rst_clr_word", rdata1, (i < 100) ? 32'h0 : 32'hFFFFFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/data_mem_be.md
Name: data_mem_be

Overview:
- Parametrised successor to the single-port data memory, placed on the datapath's load/store stage.
- Adds byte-enable writes and a configurable registered read latency (1 or 2 cycles) with a valid strobe.
- Adds alignment/range error flagging and a sequential hardware clear engine with a busy handshake.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8. BE_W = DATA_W/8.
- DEPTH, 256, number of words; power of two, at least 4. IDX_W = log2(DEPTH).
- ADDR_W, 32, byte-address width.
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- mem_access_addr  in  ADDR_W  byte address.
- mem_write_data  in  DATA_W  write data.
- mem_byte_en  in  BE_W  per-byte write enable; bit k controls bits [8k+7:8k].
- mem_write_en  in  1  write request.
- mem_read  in  1  read request.
- mem_clear  in  1  one-cycle pulse that starts the clear engine.
- mem_read_data  out  DATA_W  registered read data.
- mem_read_valid  out  1  high for exactly one cycle when mem_read_data holds the result of a read.
- mem_addr_err  out  1  registered error flag for the request issued one cycle earlier.
- mem_busy  out  1  high while the clear engine runs.

Behaviour:
- Address decode:
  - OFF_W = log2(BE_W).
  - Word index = mem_access_addr[OFF_W+IDX_W-1 : OFF_W].
  - Misaligned when mem_access_addr[OFF_W-1:0] != 0.
  - Out of range when any bit above OFF_W+IDX_W-1 is set.
  - err = misaligned OR out of range.
- Accepted request: mem_busy=0, rst_n=1, and the request bit is set.
- Write:
  - On an accepted write with err=0, each byte lane k with mem_byte_en[k]=1 is updated at the clock edge.
  - Lanes with enable 0 keep their contents.
  - When err=1 the write is suppressed; no lane changes.
- Read:
  - The accepted read samples the array at the edge it is accepted (read-first).
  - A simultaneous write to the same word returns the OLD data; the new data is visible on later reads.
  - READ_LAT=1: mem_read_data and mem_read_valid update at the same edge the read is accepted.
  - READ_LAT=2: one extra output register stage is added, so data and valid appear one edge later.
  - A read with err=1 still produces a valid pulse, with data forced to 0.
  - Back-to-back reads are accepted every cycle at full throughput; each produces its own valid pulse.
- mem_read_data holds its last value when no valid pulse is present.
- mem_addr_err:
  - Registered 1 cycle after any accepted request (read or write) whose address has err=1.
  - Otherwise 0.
  - Independent of READ_LAT.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on mem_clear=1. The clear counter loads 0 and mem_busy goes to 1 at that edge.
  - In CLEAR, one word per cycle (word at the counter index) is written to 0, then the counter increments.
  - After word DEPTH-1 is written, the FSM returns to IDLE and mem_busy drops at that same edge. Total busy time is DEPTH cycles.
  - While busy, read/write requests are ignored: no array change, no valid pulse, no error flag.
  - mem_clear while already in CLEAR is ignored.
  - mem_clear together with a read/write in IDLE: the clear starts and the request is dropped.
  - Read pipeline entries already in flight when a clear starts still complete.
- Reset (rst_n=0 at an edge):
  - FSM -> IDLE, counter -> 0.
  - mem_read_data=0, mem_read_valid=0, mem_addr_err=0, mem_busy=0; READ_LAT=2 pipeline stage cleared.
  - Array contents are NOT cleared by reset; the array is initialised to 0 at power-up only.
  - Reset during CLEAR aborts the clear: words already zeroed stay zero, the rest keep their values.
  - Requests asserted during reset are ignored.

Test Plan:
- Byte enables (READ_LAT=1): write 0xAABBCCDD to addr 0x10, BE=4'b1111; write 0x11223344 to 0x10, BE=4'b0101; read 0x10 -> next edge data=0xAA22CC44, valid=1 for one cycle.
- Read-first: same-cycle write of 0x12345678 and read of 0x20 holding 0x0 -> read data=0x0; a read of 0x20 on the next cycle -> 0x12345678.
- Error cases: read 0x22 (misaligned) -> valid=1, data=0, addr_err=1 one cycle later; write to 0x400 (DEPTH=256, out of range) -> addr_err=1, word 0 unchanged, verified by readback.
- READ_LAT=2 pipeline: reads of addrs 0, 4, 8 on consecutive cycles -> valid high on 3 consecutive cycles starting 2 edges after the first read, data in issue order.
- Clear: fill all words with 0xFFFFFFFF; pulse mem_clear -> busy=1 for exactly 256 cycles; a write issued mid-clear is ignored; after busy drops, every read returns 0.
- Reset mid-clear: assert rst_n=0 at clear cycle 100 -> busy=0, valid=0, err=0 next edge; words 0..99 read 0, word 100 and above read 0xFFFFFFFF.
